// File: rtl/mixer_pkg.sv
// Shared helpers for the mixer: tree sizing and pipeline latency derived from
// the channel count and sample width.
package mixer_pkg;

    function automatic int clog2(input int n);
        int r;
        int p;
        r = 32'sd0;
        p = 32'sd1;
        while (p < n) begin
            p = p * 32'sd2;
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Channel count rounded up to a power of two; the tree is padded with zeros.
    function automatic int pad_ch(input int n);
        return 32'sd1 << clog2(n);
    endfunction

    function automatic int gain_out_w(input int in_w);
        return in_w + 32'sd1;
    endfunction

    function automatic int sum_w(input int in_w, input int n);
        return gain_out_w(in_w) + clog2(pad_ch(n));
    endfunction

    function automatic int latency(input int n);
        return 32'sd2 + clog2(pad_ch(n));
    endfunction

endpackage

// File: rtl/mixer_add_stage.sv
// One registered level of the pairwise adder tree; the valid and average-mode
// bits travel alongside the partial sums.
module mixer_add_stage #(
    parameter int PAIRS = 4,
    parameter int W_IN  = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        src_valid,
    input  logic                        src_avg,
    input  logic [2*PAIRS*W_IN-1:0]     src_data,
    output logic                        dst_valid,
    output logic                        dst_avg,
    output logic [PAIRS*(W_IN+1)-1:0]   dst_data
);

    logic [PAIRS*(W_IN+1)-1:0] sum_s;
    logic [PAIRS*(W_IN+1)-1:0] data_r;
    logic                      valid_r;
    logic                      avg_r;

    // Widen each operand by one bit so the pair sum never overflows.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < PAIRS; i++) begin
            sum_s[i*(W_IN+1) +: (W_IN+1)] = {1'b0, src_data[(2*i)*W_IN +: W_IN]}
                                          + {1'b0, src_data[(2*i+1)*W_IN +: W_IN]};
        end
    end

    // Level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            avg_r   <= 1'b0;
            data_r  <= '0;
        end else begin
            valid_r <= src_valid;
            avg_r   <= src_avg;
            data_r  <= sum_s;
        end
    end

    assign dst_valid = valid_r;
    assign dst_avg   = avg_r;
    assign dst_data  = data_r;

endmodule

// File: rtl/mixer_pipe.sv
// Pipelined N-channel mixer: per-channel gain/mute, registered adder tree,
// optional averaging, output saturation with a retriggerable clip hold.
module mixer_pipe #(
    parameter int NUM_CH    = 8,
    parameter int IN_W      = 8,
    parameter int GAIN_W    = 4,
    parameter int OUT_W     = 32,
    parameter int CLIP_HOLD = 1024
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NUM_CH*IN_W-1:0]   audio_in,
    input  logic [NUM_CH*GAIN_W-1:0] gain_in,
    input  logic [NUM_CH-1:0]        mute,
    input  logic                     avg_mode,
    output logic                     mix_valid,
    output logic [OUT_W-1:0]         mix_down,
    output logic                     clip
);
    import mixer_pkg::*;

    localparam int P   = pad_ch(NUM_CH);
    localparam int LVL = clog2(P);
    localparam int G   = gain_out_w(IN_W);
    localparam int S   = sum_w(IN_W, NUM_CH);
    localparam int PW  = IN_W + GAIN_W;
    localparam int CW  = clog2(CLIP_HOLD + 1);

    logic [PW-1:0]      prod_s [NUM_CH];
    logic [P*G-1:0]     gain_s;
    logic [P*G-1:0]     st0_data_r;
    logic               st0_valid_r;
    logic               st0_avg_r;

    // Full-width product per channel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod_s[c] = PW'(audio_in[c*IN_W +: IN_W]) * PW'(gain_in[c*GAIN_W +: GAIN_W]);
        end
    end

    // Unity gain sits at the MSB of the gain field, hence the truncating shift.
    always_comb begin
        gain_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mute[c]) begin
                gain_s[c*G +: G] = '0;
            end else begin
                gain_s[c*G +: G] = G'(prod_s[c] >> (GAIN_W-1));
            end
        end
    end

    // Gain stage register; control is captured with its own sample.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            st0_valid_r <= 1'b0;
            st0_avg_r   <= 1'b0;
            st0_data_r  <= '0;
        end else begin
            st0_valid_r <= in_valid;
            st0_avg_r   <= avg_mode;
            st0_data_r  <= gain_s;
        end
    end

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int PAIRS = P >> (k + 1);
        localparam int W_IN  = G + k;
        logic [PAIRS*(W_IN+1)-1:0] data_s;
        logic                      valid_s;
        logic                      avg_s;
        if (k == 0) begin : g_first
            mixer_add_stage #(.PAIRS(PAIRS), .W_IN(W_IN)) u_stage (
                .clk(CLOCK_50), .rst(reset),
                .src_valid(st0_valid_r), .src_avg(st0_avg_r), .src_data(st0_data_r),
                .dst_valid(valid_s), .dst_avg(avg_s), .dst_data(data_s)
            );
        end else begin : g_next
            mixer_add_stage #(.PAIRS(PAIRS), .W_IN(W_IN)) u_stage (
                .clk(CLOCK_50), .rst(reset),
                .src_valid(g_lvl[k-1].valid_s), .src_avg(g_lvl[k-1].avg_s),
                .src_data(g_lvl[k-1].data_s),
                .dst_valid(valid_s), .dst_avg(avg_s), .dst_data(data_s)
            );
        end
    end

    logic [S-1:0]     sum_s;
    logic [S-1:0]     r_s;
    logic             last_valid_s;
    logic             last_avg_s;
    logic [OUT_W-1:0] out_s;
    logic             clip_evt_s;

    assign sum_s        = g_lvl[LVL-1].data_s;
    assign last_valid_s = g_lvl[LVL-1].valid_s;
    assign last_avg_s   = g_lvl[LVL-1].avg_s;

    // Averaging divides by the padded channel count, not NUM_CH.
    always_comb begin
        if (last_avg_s) begin
            r_s = sum_s >> LVL;
        end else begin
            r_s = sum_s;
        end
    end

    if (OUT_W >= S) begin : g_wide
        // Output is wide enough for any sum.
        always_comb begin
            out_s      = OUT_W'(r_s);
            clip_evt_s = 1'b0;
        end
    end else begin : g_narrow
        localparam logic [S-1:0] SAT_MAX = S'({OUT_W{1'b1}});
        // Clamp to full scale and flag the clip.
        always_comb begin
            if (r_s > SAT_MAX) begin
                out_s      = {OUT_W{1'b1}};
                clip_evt_s = 1'b1;
            end else begin
                out_s      = r_s[OUT_W-1:0];
                clip_evt_s = 1'b0;
            end
        end
    end

    logic             mix_valid_r;
    logic [OUT_W-1:0] mix_down_r;
    logic [CW-1:0]    clip_cnt_r;
    logic [CW-1:0]    clip_cnt_nxt_s;
    logic             clip_r;

    // Hold counter: a clipped output reloads it, otherwise it drains to zero.
    always_comb begin
        if (last_valid_s && clip_evt_s) begin
            clip_cnt_nxt_s = CW'(CLIP_HOLD);
        end else if (clip_cnt_r != '0) begin
            clip_cnt_nxt_s = clip_cnt_r - CW'(32'd1);
        end else begin
            clip_cnt_nxt_s = clip_cnt_r;
        end
    end

    // Output register; mix_down only moves when a valid sample arrives.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mix_valid_r <= 1'b0;
            mix_down_r  <= '0;
            clip_cnt_r  <= '0;
            clip_r      <= 1'b0;
        end else begin
            mix_valid_r <= last_valid_s;
            if (last_valid_s) begin
                mix_down_r <= out_s;
            end
            clip_cnt_r <= clip_cnt_nxt_s;
            clip_r     <= (clip_cnt_nxt_s != '0);
        end
    end

    assign mix_valid = mix_valid_r;
    assign mix_down  = mix_down_r;
    assign clip      = clip_r;

endmodule

// File: tb/tb_mixer_pipe.sv
// Bench for mixer_pipe: three builds (default, 10-bit saturating output, five
// channels) share one stimulus stream and are checked against a sample-level model.
module tb_mixer_pipe;

    localparam int LAT      = 5;
    localparam int SAT_HOLD = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        avg_mode;
    logic [63:0] audio_in;
    logic [31:0] gain_in;
    logic [7:0]  mute;

    logic        mv_def, mv_sat, mv_ch5;
    logic        cl_def, cl_sat, cl_ch5;
    logic [31:0] md_def, md_ch5;
    logic [9:0]  md_sat;

    always #5 clk = ~clk;

    mixer_pipe #(.NUM_CH(8), .IN_W(8), .GAIN_W(4), .OUT_W(32), .CLIP_HOLD(1024)) u_def (
        .CLOCK_50(clk), .reset(reset), .in_valid(in_valid), .audio_in(audio_in),
        .gain_in(gain_in), .mute(mute), .avg_mode(avg_mode),
        .mix_valid(mv_def), .mix_down(md_def), .clip(cl_def));

    mixer_pipe #(.NUM_CH(8), .IN_W(8), .GAIN_W(4), .OUT_W(10), .CLIP_HOLD(SAT_HOLD)) u_sat (
        .CLOCK_50(clk), .reset(reset), .in_valid(in_valid), .audio_in(audio_in),
        .gain_in(gain_in), .mute(mute), .avg_mode(avg_mode),
        .mix_valid(mv_sat), .mix_down(md_sat), .clip(cl_sat));

    mixer_pipe #(.NUM_CH(5), .IN_W(8), .GAIN_W(4), .OUT_W(32), .CLIP_HOLD(1024)) u_ch5 (
        .CLOCK_50(clk), .reset(reset), .in_valid(in_valid), .audio_in(audio_in[39:0]),
        .gain_in(gain_in[19:0]), .mute(mute[4:0]), .avg_mode(avg_mode),
        .mix_valid(mv_ch5), .mix_down(md_ch5), .clip(cl_ch5));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample-level model: floor(a*g/8) per unmuted channel, summed, optionally
    // divided by the padded channel count, then clamped to the output range.
    function automatic logic [63:0] model_mix(input int nch, input int out_w,
            input logic [63:0] a, input logic [31:0] g, input logic [7:0] m,
            input logic av, output bit clipped);
        longint sum;
        longint lim;
        int p;
        sum = 0;
        p = 1;
        while (p < nch) p = p * 2;
        for (int c = 0; c < nch; c++) begin
            if (!m[c]) sum += (longint'(a[c*8 +: 8]) * longint'(g[c*4 +: 4])) / 8;
        end
        if (av) sum = sum / p;
        lim = (longint'(1) << out_w) - 1;
        clipped = (sum > lim);
        if (clipped) sum = lim;
        return sum;
    endfunction

    int nch_t  [3] = '{8, 8, 5};
    int ow_t   [3] = '{32, 10, 32};
    int hold_t [3] = '{1024, SAT_HOLD, 1024};

    function automatic logic [63:0] act_d(input int d);
        case (d)
            0:       return {32'd0, md_def};
            1:       return {54'd0, md_sat};
            default: return {32'd0, md_ch5};
        endcase
    endfunction

    function automatic logic act_v(input int d);
        case (d)
            0:       return mv_def;
            1:       return mv_sat;
            default: return mv_ch5;
        endcase
    endfunction

    function automatic logic act_c(input int d);
        case (d)
            0:       return cl_def;
            1:       return cl_sat;
            default: return cl_ch5;
        endcase
    endfunction

    // Scoreboard keyed by the cycle a sample must appear in.
    bit          ev [int];
    logic [63:0] ed [int];
    bit          ec [int];
    logic [63:0] last_d [3] = '{64'd0, 64'd0, 64'd0};
    int          clip_end [3] = '{0, 0, 0};

    always @(posedge clk) begin : cmp_blk
        bit clp;
        int k;
        bit v;
        cyc = cyc + 1;
        if (reset) begin
            ev.delete();
            ed.delete();
            ec.delete();
            for (int d = 0; d < 3; d++) begin
                last_d[d]   = 64'd0;
                clip_end[d] = 0;
            end
        end else if (in_valid) begin
            for (int d = 0; d < 3; d++) begin
                k = (cyc + LAT - 1) * 4 + d;
                ed[k] = model_mix(nch_t[d], ow_t[d], audio_in, gain_in, mute, avg_mode, clp);
                ev[k] = 1'b1;
                ec[k] = clp;
            end
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            k = cyc * 4 + d;
            v = ev.exists(k);
            chk($sformatf("mix_valid[%0d]@%0d", d, cyc), {63'd0, act_v(d)}, {63'd0, v});
            if (v) begin
                last_d[d] = ed[k];
                if (ec[k]) clip_end[d] = cyc + hold_t[d];
            end
            chk($sformatf("mix_down[%0d]@%0d", d, cyc), act_d(d), last_d[d]);
            chk($sformatf("clip[%0d]@%0d", d, cyc), {63'd0, act_c(d)}, {63'd0, cyc < clip_end[d]});
        end
    end

    task automatic drive(input logic [63:0] a, input logic [31:0] g, input logic [7:0] m, input logic av);
        @(negedge clk);
        in_valid = 1'b1;
        audio_in = a;
        gain_in  = g;
        mute     = m;
        avg_mode = av;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            audio_in = {$urandom, $urandom};
            gain_in  = $urandom;
            mute     = 8'($urandom);
            avg_mode = 1'($urandom);
        end
    endtask

    // Single sample; mix_valid must rise exactly LAT cycles later on both 8- and 5-channel builds.
    task automatic lat_check(input string name, input logic [63:0] a, input logic [31:0] g,
                             input logic [63:0] exp_def, input logic [63:0] exp_ch5);
        drive(a, g, 8'h00, 1'b0);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_valid = 1'b0;
            chk({name, "_valid_def"}, {63'd0, mv_def}, {63'd0, k == LAT});
            chk({name, "_valid_ch5"}, {63'd0, mv_ch5}, {63'd0, k == LAT});
            if (k == LAT) begin
                chk({name, "_down_def"}, {32'd0, md_def}, exp_def);
                chk({name, "_down_ch5"}, {32'd0, md_ch5}, exp_ch5);
                chk({name, "_clip_def"}, {63'd0, cl_def}, 64'd0);
            end
        end
    endtask

    // Counts clip-high cycles after a saturating sample, with an optional retrigger.
    task automatic clip_span(input int retrig, output int n);
        drive({8{8'hFF}}, {8{4'hF}}, 8'h00, 1'b0);
        n = 0;
        for (int i = 0; i < SAT_HOLD + 40; i++) begin
            @(negedge clk);
            if (cl_sat) n++;
            in_valid = (i == retrig);
        end
    endtask

    initial begin
        bit c;
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        audio_in = 64'd0;
        gain_in  = 32'd0;
        mute     = 8'd0;
        avg_mode = 1'b0;

        chk("model_sum",  model_mix(8, 32, {8{8'hFF}}, {8{4'h8}}, 8'h00, 1'b0, c), 64'd2040);
        chk("model_avg",  model_mix(8, 32, {8{8'hFF}}, {8{4'h8}}, 8'h00, 1'b1, c), 64'd255);
        chk("model_gain", model_mix(8, 32, 64'h00000000000000FF, 32'h8888888F, 8'h00, 1'b0, c), 64'd478);
        chk("model_sat",  model_mix(8, 10, {8{8'hFF}}, {8{4'hF}}, 8'h00, 1'b0, c), 64'd1023);
        chk("model_sat_flag", {63'd0, c}, 64'd1);
        chk("model_ch5",  model_mix(5, 32, {8{8'h0A}}, {8{4'h8}}, 8'h00, 1'b0, c), 64'd50);

        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, mv_def}, 64'd0);
        chk("rst_down",  {32'd0, md_def}, 64'd0);
        chk("rst_clip",  {63'd0, cl_sat}, 64'd0);
        reset = 1'b0;
        idle(2);

        // Sum mode, full-scale channels.
        lat_check("t1", {8{8'hFF}}, {8{4'h8}}, 64'd2040, 64'd1275);
        chk("t1_sat_down", {54'd0, md_sat}, 64'd1023);
        chk("t1_sat_clip", {63'd0, cl_sat}, 64'd1);
        idle(2);

        // Average mode and a single boosted channel.
        drive({8{8'hFF}}, {8{4'h8}}, 8'h00, 1'b1);
        idle(LAT + 1);
        chk("t2_avg", {32'd0, md_def}, 64'd255);
        drive(64'h00000000000000FF, 32'h8888888F, 8'h00, 1'b0);
        idle(LAT + 1);
        chk("t2_gain15", {32'd0, md_def}, 64'd478);

        // Mute patterns.
        drive({8{8'h64}}, {8{4'h8}}, 8'hF0, 1'b0);
        idle(LAT + 1);
        chk("t3_mute_f0", {32'd0, md_def}, 64'd400);
        drive({8{8'h64}}, {8{4'h8}}, 8'hFF, 1'b0);
        idle(LAT + 1);
        chk("t3_mute_ff", {32'd0, md_def}, 64'd0);

        // Saturation, hold length and retrigger on the 10-bit build.
        idle(SAT_HOLD + 2);
        clip_span(-1, n);
        chk("t4_clip_len", n, SAT_HOLD);
        chk("t4_sat_down", {54'd0, md_sat}, 64'd1023);
        clip_span(10, n);
        chk("t4_retrig_len", n, SAT_HOLD + 11);

        // Back-to-back ramp with a gain change mid-stream.
        for (int i = 0; i < 16; i++) begin
            drive({56'd0, 8'(i)}, (i < 8) ? 32'h88888888 : 32'h8888888C, 8'h00, 1'b0);
        end
        idle(LAT + 1);
        chk("t5_last", {32'd0, md_def}, 64'd22);

        // Reset in mid-stream discards in-flight samples.
        drive({8{8'd30}}, {8{4'h8}}, 8'h00, 1'b0);
        drive({8{8'd31}}, {8{4'h8}}, 8'h00, 1'b0);
        drive({8{8'd32}}, {8{4'h8}}, 8'h00, 1'b0);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_down",  {32'd0, md_def}, 64'd0);
        chk("t6_rst_valid", {63'd0, mv_def}, 64'd0);
        chk("t6_rst_sat",   {54'd0, md_sat}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (mv_def || mv_sat || mv_ch5) n++;
        end
        chk("t6_no_valid", n, 0);
        lat_check("t6_after", {8{8'd20}}, {8{4'h8}}, 64'd160, 64'd100);

        // Five-channel build padded to eight.
        lat_check("t7", {8{8'h0A}}, {8{4'h8}}, 64'd80, 64'd50);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
